// File: rtl/mips_mem_pkg.sv
// Shared encodings for the unified MIPS memory port arbiter.
//   state_e : arbiter FSM states
//   grant_e : which requester currently owns the port
//   is_misaligned() : word-alignment check on the low address bits
package mips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    typedef enum logic {
        FETCH = 1'b0,
        DATA  = 1'b1
    } grant_e;

    localparam logic [1:0] ALIGN_MASK = 2'b11;

    // Word accesses only: any set bit under the mask is a misaligned address.
    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return (addr_lsb & ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/access_timer.sv
// Counts ACCESS cycles without an acknowledge and flags expiry.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : restart the count (held while no access is in flight)
//   en         : count this cycle (in ACCESS and no ack)
//   expired_c  : this counting cycle brings the count to TIMEOUT
module access_timer #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired_c
);
    localparam int unsigned CNT_W = 8;

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    // Reached on the cycle whose edge would make the count equal TIMEOUT.
    assign expired_c = en && (count_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single unified memory port between fetch and load/store.
//   if_*   : fetch requester (req level in, done pulse + rdata out)
//   d_*    : data requester (req/we/addr/wdata in, done pulse + rdata out)
//   mem_*  : memory port (en/we/addr/wdata out, rdata/ack in)
//   busy   : arbiter not idle;  err : sticky timeout/misalignment flag
module mem_port_arbiter
    import mips_mem_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              busy,
    output logic              err
);

    state_e            state_q, state_d;
    grant_e            grant_q, grant_d;
    grant_e            last_grant_q, last_grant_d;
    grant_e            pick_c;
    logic              any_req_c;
    logic [ADDR_W-1:0] sel_addr_c;
    logic              sel_misaligned_c;
    logic              expired_c;

    logic              if_done_d, d_done_d, mem_en_d, mem_we_d, busy_d, err_d;
    logic [DATA_W-1:0] if_rdata_d, d_rdata_d, mem_wdata_d;
    logic [ADDR_W-1:0] mem_addr_d;

    access_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (state_q == IDLE),
        .en        ((state_q == ACCESS) && !mem_ack),
        .expired_c (expired_c)
    );

    // Requester selection: on a tie, the one not served last.
    always_comb begin
        any_req_c = if_req || d_req;
        pick_c    = FETCH;
        if (if_req && d_req) begin
            pick_c = (last_grant_q == FETCH) ? DATA : FETCH;
        end else if (d_req) begin
            pick_c = DATA;
        end
        sel_addr_c       = (pick_c == DATA) ? d_addr : if_addr;
        sel_misaligned_c = is_misaligned(sel_addr_c[1:0]);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req_c) state_d = sel_misaligned_c ? DONE : ACCESS;
            ACCESS:  if (mem_ack || expired_c) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of every registered output.
    always_comb begin
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        if_done_d    = 1'b0;
        d_done_d     = 1'b0;
        if_rdata_d   = if_rdata;
        d_rdata_d    = d_rdata;
        mem_en_d     = mem_en;
        mem_we_d     = mem_we;
        mem_addr_d   = mem_addr;
        mem_wdata_d  = mem_wdata;
        err_d        = err;
        busy_d       = (state_d != IDLE);

        case (state_q)
            IDLE: begin
                if (any_req_c) begin
                    grant_d      = pick_c;
                    last_grant_d = pick_c;
                    mem_addr_d   = sel_addr_c;
                    if (pick_c == DATA) mem_wdata_d = d_wdata;
                    if (sel_misaligned_c) begin
                        // No memory cycle, so no write strobe either.
                        mem_en_d = 1'b0;
                        mem_we_d = 1'b0;
                        err_d    = 1'b1;
                        if (pick_c == DATA) begin
                            d_rdata_d = '0;
                            d_done_d  = 1'b1;
                        end else begin
                            if_rdata_d = '0;
                            if_done_d  = 1'b1;
                        end
                    end else begin
                        mem_en_d = 1'b1;
                        mem_we_d = (pick_c == DATA) && d_we;
                    end
                end
            end
            ACCESS: begin
                // Ack takes priority over a simultaneous timeout.
                if (mem_ack) begin
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    if (grant_q == DATA) begin
                        if (!mem_we) d_rdata_d = mem_rdata;
                        d_done_d = 1'b1;
                    end else begin
                        if_rdata_d = mem_rdata;
                        if_done_d  = 1'b1;
                    end
                end else if (expired_c) begin
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    err_d    = 1'b1;
                    if (grant_q == DATA) begin
                        d_rdata_d = '0;
                        d_done_d  = 1'b1;
                    end else begin
                        if_rdata_d = '0;
                        if_done_d  = 1'b1;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // Output and grant registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant_q      <= FETCH;
            last_grant_q <= FETCH;
            if_done      <= 1'b0;
            d_done       <= 1'b0;
            if_rdata     <= '0;
            d_rdata      <= '0;
            mem_en       <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            busy         <= 1'b0;
            err          <= 1'b0;
        end else begin
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            if_done      <= if_done_d;
            d_done       <= d_done_d;
            if_rdata     <= if_rdata_d;
            d_rdata      <= d_rdata_d;
            mem_en       <= mem_en_d;
            mem_we       <= mem_we_d;
            mem_addr     <= mem_addr_d;
            mem_wdata    <= mem_wdata_d;
            busy         <= busy_d;
            err          <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes the expected
// completion, a monitor pops and compares on every done pulse.
module tb_mem_port_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          clk;
    logic          rst_n;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_done;
    logic [DW-1:0] if_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_done;
    logic [DW-1:0] d_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic          busy;
    logic          err;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(15)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_done   (if_done),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_done    (d_done),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .busy      (busy),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_data;
        logic [31:0] rdata;
        bit          err;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push_exp(input bit is_data, input logic [31:0] rdata, input bit e);
        exp_t x;
        x.is_data = is_data;
        x.rdata   = rdata;
        x.err     = e;
        exp_q.push_back(x);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (if_done === 1'b1 || d_done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", {30'd0, if_done, d_done}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("done_port", {30'd0, if_done, d_done}, e.is_data ? 32'd1 : 32'd2);
                    check(e.is_data ? "d_rdata" : "if_rdata",
                          e.is_data ? d_rdata : if_rdata, e.rdata);
                    check("err_at_done", {31'd0, err}, {31'd0, e.err});
                end
            end
        end
    end

    // Memory model: acks on the delay-th cycle of mem_en (0 = never).
    task automatic serve(input int delay, input logic [31:0] rd, output int cycles,
                         output logic we, output logic [31:0] addr,
                         output logic [31:0] wdata, output bit stable);
        int guard = 0;
        cycles = 0;
        stable = 1'b1;
        we     = 1'bx;
        addr   = 'x;
        wdata  = 'x;
        while (mem_en !== 1'b1 && guard < 30) begin
            @(negedge clk);
            guard++;
        end
        if (mem_en !== 1'b1) begin
            check("mem_en_rise", {31'd0, mem_en}, 32'd1);
            return;
        end
        we    = mem_we;
        addr  = mem_addr;
        wdata = mem_wdata;
        while (mem_en === 1'b1 && cycles < 40) begin
            cycles++;
            if (mem_we !== we || mem_addr !== addr || mem_wdata !== wdata) stable = 1'b0;
            if (cycles == delay) begin
                mem_ack   = 1'b1;
                mem_rdata = rd;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 32'hDEAD_BEEF;
            end
            @(negedge clk);
        end
        mem_ack = 1'b0;
    endtask

    // Wait (bounded) for a done pulse, then drop that requester's req.
    task automatic wait_done();
        int guard = 0;
        while (!(if_done === 1'b1 || d_done === 1'b1) && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (!(if_done === 1'b1 || d_done === 1'b1)) check("done_timeout", 32'd0, 32'd1);
        if (if_done === 1'b1) if_req = 1'b0;
        if (d_done === 1'b1) d_req = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc;
        logic        we;
        logic [31:0] addr, wdata;
        bit          stable, seen;

        rst_n = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_mem_en",   {31'd0, mem_en},  32'd0);
        check("rst_mem_we",   {31'd0, mem_we},  32'd0);
        check("rst_busy",     {31'd0, busy},    32'd0);
        check("rst_err",      {31'd0, err},     32'd0);
        check("rst_dones",    {30'd0, if_done, d_done}, 32'd0);
        check("rst_if_rdata", if_rdata, 32'd0);
        check("rst_d_rdata",  d_rdata,  32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        rst_n = 1'b1;

        // Single fetch, ack on the second mem_en cycle.
        push_exp(1'b0, 32'h2008_0005, 1'b0);
        if_req = 1'b1; if_addr = 32'h0000_0010;
        serve(2, 32'h2008_0005, cyc, we, addr, wdata, stable);
        check("fetch_en_cycles", cyc, 32'd2);
        check("fetch_we", {31'd0, we}, 32'd0);
        check("fetch_addr", addr, 32'h10);
        check("fetch_stable", {31'd0, stable}, 32'd1);
        wait_done();
        check("fetch_d_rdata_hold", d_rdata, 32'd0);

        // Load, ack on the third cycle; if_rdata must not move.
        push_exp(1'b1, 32'h1234_5678, 1'b0);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
        serve(3, 32'h1234_5678, cyc, we, addr, wdata, stable);
        check("load_en_cycles", cyc, 32'd3);
        check("load_addr", addr, 32'h80);
        wait_done();
        check("load_if_rdata_hold", if_rdata, 32'h2008_0005);

        // Store with immediate ack; d_rdata keeps the previous load value.
        push_exp(1'b1, 32'h1234_5678, 1'b0);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hCAFE_F00D;
        serve(1, 32'h5555_AAAA, cyc, we, addr, wdata, stable);
        check("store_en_cycles", cyc, 32'd1);
        check("store_we", {31'd0, we}, 32'd1);
        check("store_addr", addr, 32'h40);
        check("store_wdata", wdata, 32'hCAFE_F00D);
        wait_done();
        check("store_we_dropped", {31'd0, mem_we}, 32'd0);
        d_we = 1'b0;

        // Tie straight after reset: data first, then fetch.
        do_reset();
        check("rst2_if_rdata", if_rdata, 32'd0);
        push_exp(1'b1, 32'h1111_1111, 1'b0);
        push_exp(1'b0, 32'h2222_2222, 1'b0);
        if_req = 1'b1; if_addr = 32'h100;
        d_req = 1'b1; d_addr = 32'h200;
        serve(1, 32'h1111_1111, cyc, we, addr, wdata, stable);
        check("tie1_first_addr", addr, 32'h200);
        wait_done();
        serve(2, 32'h2222_2222, cyc, we, addr, wdata, stable);
        check("tie1_second_addr", addr, 32'h100);
        wait_done();

        // A lone load leaves last_grant = DATA, so the next tie goes to fetch.
        push_exp(1'b1, 32'h3333_3333, 1'b0);
        d_req = 1'b1; d_addr = 32'h300;
        serve(1, 32'h3333_3333, cyc, we, addr, wdata, stable);
        wait_done();
        push_exp(1'b0, 32'h4444_4444, 1'b0);
        push_exp(1'b1, 32'h5555_5555, 1'b0);
        if_req = 1'b1; if_addr = 32'h104;
        d_req = 1'b1; d_addr = 32'h204;
        serve(1, 32'h4444_4444, cyc, we, addr, wdata, stable);
        check("tie2_first_addr", addr, 32'h104);
        wait_done();
        serve(1, 32'h5555_5555, cyc, we, addr, wdata, stable);
        check("tie2_second_addr", addr, 32'h204);
        wait_done();

        // Timeout: no ack ever, mem_en lasts exactly 15 cycles, err sticks.
        check("pre_timeout_err", {31'd0, err}, 32'd0);
        push_exp(1'b0, 32'd0, 1'b1);
        if_req = 1'b1; if_addr = 32'h20;
        serve(0, 32'd0, cyc, we, addr, wdata, stable);
        check("timeout_en_cycles", cyc, 32'd15);
        wait_done();
        repeat (10) @(negedge clk);
        check("timeout_err_sticky", {31'd0, err}, 32'd1);
        check("timeout_idle_busy", {31'd0, busy}, 32'd0);

        // Reset mid-access abandons the access; a late ack is ignored.
        if_req = 1'b1; if_addr = 32'h30;
        cyc = 0;
        while (mem_en !== 1'b1 && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        check("midrst_en_rise", {31'd0, mem_en}, 32'd1);
        @(negedge clk);
        if_req = 1'b0;
        do_reset();
        check("midrst_mem_en", {31'd0, mem_en}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_err", {31'd0, err}, 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
        @(negedge clk);
        mem_ack = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (if_done === 1'b1 || d_done === 1'b1 || mem_en === 1'b1) seen = 1'b1;
            @(negedge clk);
        end
        check("late_ack_ignored", {31'd0, seen}, 32'd0);

        // Misaligned load: no memory cycle, d_done right after the grant edge.
        push_exp(1'b1, 32'd0, 1'b1);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h42;
        cyc = 0;
        seen = 1'b0;
        while (!(d_done === 1'b1 || if_done === 1'b1) && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (mem_en === 1'b1) seen = 1'b1;
        end
        d_req = 1'b0;
        check("misalign_no_mem_en", {31'd0, seen}, 32'd0);
        check("misalign_latency", cyc, 32'd1);
        repeat (3) @(negedge clk);
        check("misalign_err", {31'd0, err}, 32'd1);
        check("misalign_no_mem_en_after", {31'd0, mem_en}, 32'd0);

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
